// File: rtl/apb_master_bridge.sv
// Single-beat command to APB requester: turns one host command into a SETUP/ACCESS
// transfer and reports completion or timeout through a one-cycle response strobe.
module apb_master_bridge #(
  parameter int addrWidth     = 8,
  parameter int dataWidth     = 91,
  parameter int timeoutCycles = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  localparam int CntW = (timeoutCycles < 1) ? 1 : $clog2(timeoutCycles + 1);
  localparam bit TimeoutEn = (timeoutCycles != 0);
  localparam logic [CntW-1:0] TimeoutLast = CntW'((timeoutCycles > 0) ? timeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e               state_q, state_d;
  logic [addrWidth-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [dataWidth-1:0] pwdata_q, pwdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 idle;

  assign idle      = (state_q == IDLE);
  assign cmd_ready = idle;
  assign busy      = ~idle;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = (wait_cnt_q == CntMax) ? wait_cnt_q : wait_cnt_q + CntW'(1);
          // Counter holds the number of waits already seen, so the abort lands
          // on the timeoutCycles-th ACCESS cycle.
          if (TimeoutEn && (wait_cnt_q == TimeoutLast)) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: the bench plays host and APB slave and
// predicts each transfer's shape from its wait-state count and the timeout limit.
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 91;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  apb_master_bridge #(.addrWidth(AW), .dataWidth(DW), .timeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Last response and last address the bench expects the bridge to hold.
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err   = 1'b0;
  logic [AW-1:0] exp_paddr = '0;
  int            last_rsp_cyc = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      pready = 1'($urandom_range(0, 1));
      prdata = rand_data();
      @(negedge clk);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_psel", {psel, penable}, 0);
      check("idle_ready", {cmd_ready, busy}, 2'b10);
      check("idle_rdata_hold", rsp_rdata, exp_rdata);
      check("idle_err_hold", rsp_err, exp_err);
      check("idle_paddr_hold", paddr, exp_paddr);
    end
    pready = 1'b0;
  endtask

  // mode 0: quiet host; 1: stray cmd_valid pulse during SETUP; 2: cmd_valid held high while busy.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rd, input int mode);
    int t0;
    int n_access;
    bit timeout;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_before_cmd", cmd_ready, 1);
    if (!cmd_ready) return;
    timeout  = (waits >= TO);
    n_access = timeout ? TO : waits + 1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    pready    = 1'($urandom_range(0, 1));
    @(negedge clk);
    t0 = cyc;
    // SETUP cycle
    cmd_valid = (mode != 0);
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wd;
    check("setup_psel_penable", {psel, penable}, 2'b10);
    check("setup_busy", {cmd_ready, busy}, 2'b01);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, wd);
    check("setup_rsp_valid", rsp_valid, 0);
    pready = 1'($urandom_range(0, 1));
    for (int i = 0; i < n_access; i++) begin
      @(negedge clk);
      if (mode == 1) cmd_valid = 1'b0;
      check("access_psel_penable", {psel, penable}, 2'b11);
      check("access_paddr", paddr, addr);
      check("access_pwrite", pwrite, wr);
      check("access_pwdata", pwdata, wd);
      check("access_rsp_valid", rsp_valid, 0);
      pready = (i == waits);
      prdata = (i == waits) ? rd : rand_data();
    end
    @(negedge clk);
    pready = 1'b0;
    exp_err   = timeout;
    exp_rdata = (timeout || wr) ? '0 : rd;
    exp_paddr = addr;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_latency", cyc - t0, n_access + 1);
    check("rsp_psel_penable", {psel, penable}, 2'b00);
    check("rsp_cmd_ready", {cmd_ready, busy}, 2'b10);
    check("rsp_paddr_hold", paddr, addr);
    check("rsp_pwdata_hold", pwdata, wd);
    last_rsp_cyc = cyc;
  endtask

  initial begin
    int prev;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_apb", {psel, penable, pwrite}, 0);
    check("reset_paddr", paddr, 0);
    check("reset_pwdata", pwdata, 0);
    check("reset_rsp", {rsp_valid, rsp_err}, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_ready", {cmd_ready, busy}, 2'b10);
    idle_check(1);

    // Directed: plain write, read with 2 waits, timeout boundary on both sides.
    xfer(1'b1, 8'h04, 91'h1234, 0, '0, 0);
    cmd_valid = 1'b0; idle_check(1);
    xfer(1'b0, 8'h10, 91'h5, 2, 91'hABC, 0);
    cmd_valid = 1'b0; idle_check(1);
    xfer(1'b0, 8'h11, '0, TO - 1, rand_data(), 0);
    cmd_valid = 1'b0; idle_check(1);
    xfer(1'b0, 8'h12, '0, TO + 10, rand_data(), 0);
    cmd_valid = 1'b0; idle_check(2);

    // Back-to-back writes with cmd_valid held high.
    for (int a = 0; a < 4; a++) begin
      prev = last_rsp_cyc;
      xfer(1'b1, AW'(a), rand_data(), 0, '0, 2);
      if (a > 0) check("b2b_spacing", last_rsp_cyc - prev, 3);
    end
    cmd_valid = 1'b0; idle_check(1);

    // Stray command during SETUP must not start a second transfer.
    xfer(1'b1, 8'h20, rand_data(), 1, '0, 1);
    cmd_valid = 1'b0; idle_check(3);

    // Reset during ACCESS of a read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; cmd_wdata = rand_data();
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_access", {psel, penable}, 2'b11);
    rst_n = 1'b0; pready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0; exp_err = 1'b0; exp_paddr = '0;
    check("rst_mid_apb", {psel, penable}, 0);
    check("rst_mid_rsp", rsp_valid, 0);
    check("rst_mid_ready", cmd_ready, 1);
    idle_check(2);
    xfer(1'b0, 8'h31, rand_data(), 0, 91'h77, 0);
    cmd_valid = 1'b0; idle_check(1);

    // Randomized transfers, occasionally back-to-back.
    for (int k = 0; k < 40; k++) begin
      int w;
      int gap;
      w   = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
      gap = $urandom_range(0, 2);
      xfer(1'($urandom_range(0, 1)), AW'($urandom()), rand_data(), w, rand_data(),
           $urandom_range(0, 2));
      if (gap > 0) begin
        cmd_valid = 1'b0;
        idle_check(gap);
      end
    end
    cmd_valid = 1'b0;
    idle_check(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
